// File: rtl/audio_out.sv
// audio_out: sample tick, sample capture with mute ramp, 1-bit audio output.
// Optional: define AUDIO_SDM_EN to swap the PWM comparator for a sigma-delta.
module audio_out #(
  parameter int CLK_HZ      = 25000000,
  parameter int SAMPLE_RATE = 16384
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sample,
  input  logic       mute,
  output logic       sample_ena,
  output logic       pwm_out,
  output logic [3:0] level_o,
  output logic [4:0] gain_o,
  output logic       muted
);
  localparam int AW = $clog2(CLK_HZ) + 1;
  localparam logic [AW-1:0] STEP  = AW'(SAMPLE_RATE);
  localparam logic [AW-1:0] LIMIT = AW'(CLK_HZ);

  logic [AW-1:0] r_acc;
  logic          r_ena;
  logic          r_ena_d;
  logic [3:0]    r_smp;
  logic [4:0]    r_gain;
  logic [3:0]    r_level;
  logic [3:0]    r_pwm_cnt;
  logic          r_pwm;

  logic [AW-1:0]      w_nxt;
  logic [4:0]         w_gain_nxt;
  logic [4:0]         w_s;
  logic signed [9:0]  w_prod;
  logic [3:0]         w_level;

  assign w_nxt = r_acc + STEP;

  // Fractional accumulator: SAMPLE_RATE ticks per CLK_HZ clocks
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_ena <= 1'b0;
    end else if (w_nxt >= LIMIT) begin
      r_acc <= w_nxt - LIMIT;
      r_ena <= 1'b1;
    end else begin
      r_acc <= w_nxt;
      r_ena <= 1'b0;
    end
  end

  always_comb begin
    w_gain_nxt = r_gain;
    if (mute) begin
      if (r_gain != 5'd0) w_gain_nxt = r_gain - 5'd1;
    end else begin
      if (r_gain != 5'd16) w_gain_nxt = r_gain + 5'd1;
    end
  end

  // Capture one clock after the tick so the generator output has settled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ena_d <= 1'b0;
      r_smp   <= 4'd8;
      r_gain  <= 5'd0;
    end else begin
      r_ena_d <= r_ena;
      if (r_ena_d) begin
        r_smp  <= sample;
        r_gain <= w_gain_nxt;
      end
    end
  end

  assign w_s     = {1'b0, r_smp} - 5'd8;
  assign w_prod  = $signed({{5{w_s[4]}}, w_s}) * $signed({5'b0, r_gain});
  assign w_level = 4'(w_prod >>> 4) + 4'd8;

  // Level only lands on PWM period boundaries
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pwm_cnt <= 4'd0;
      r_level   <= 4'd8;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
      if (r_pwm_cnt == 4'd15) r_level <= w_level;
    end
  end

`ifdef AUDIO_SDM_EN
  logic [3:0] r_sdm_acc;
  logic [4:0] w_sdm_sum;

  assign w_sdm_sum = {1'b0, r_sdm_acc} + {1'b0, r_level};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sdm_acc <= 4'd0;
      r_pwm     <= 1'b0;
    end else begin
      r_sdm_acc <= w_sdm_sum[3:0];
      r_pwm     <= w_sdm_sum[4];
    end
  end
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_pwm <= 1'b0;
    else       r_pwm <= (r_pwm_cnt < r_level);
  end
`endif

  assign sample_ena = r_ena;
  assign pwm_out    = r_pwm;
  assign level_o    = r_level;
  assign gain_o     = r_gain;
  assign muted      = mute & (r_gain == 5'd0);

endmodule

// File: tb/tb_audio_out.sv
// tb_audio_out: scoreboard bench for audio_out at CLK_HZ=100, SAMPLE_RATE=8.
// Expected ticks, gains and per-period levels are queued by stimulus.
module tb_audio_out;
  localparam int CLK_HZ = 100;
  localparam int SR     = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sample = 4'd8;
  logic       mute = 1'b0;
  logic       sample_ena;
  logic       pwm_out;
  logic [3:0] level_o;
  logic [4:0] gain_o;
  logic       muted;

  audio_out #(.CLK_HZ(CLK_HZ), .SAMPLE_RATE(SR)) dut (
    .clock      (clock),
    .reset      (reset),
    .sample     (sample),
    .mute       (mute),
    .sample_ena (sample_ena),
    .pwm_out    (pwm_out),
    .level_o    (level_o),
    .gain_o     (gain_o),
    .muted      (muted)
  );

  always #5 clock = ~clock;

  typedef struct { int g; int m; } gain_t;
  typedef struct { bit chk; int lvl; } per_t;

  int    q_tick[$];
  gain_t q_gain[$];
  per_t  q_per[$];

  int n_pass = 0;
  int n_total = 0;
  int edge_n;

  function automatic void check(string name, int act, int exp);
    n_total++;
    if (act != exp)
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    else
      n_pass++;
  endfunction

  always @(posedge clock or posedge reset)
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;

  logic [1:0]  sh;
  logic [15:0] w_pat;
  int          w_lvl;
  bit          w_stable;
  int          j;
  int          e;
  int          mask;
  gain_t       gg;
  per_t        pp;

  // Monitor: pops expectations as the DUT produces ticks, captures, periods
  always @(negedge clock) begin
    if (reset || edge_n == 0) begin
      sh = 2'b00;
    end else begin
      if (sample_ena && q_tick.size() > 0) begin
        e = q_tick.pop_front();
        check("tick_edge", edge_n, e);
      end
      if (sh[1] && q_gain.size() > 0) begin
        gg = q_gain.pop_front();
        check("gain", int'(gain_o), gg.g);
        check("muted", int'(muted), gg.m);
      end
      sh = {sh[0], sample_ena};
      j = (edge_n - 1) % 16;
      if (j == 0) begin
        w_lvl = int'(level_o);
        w_pat = 16'h0;
        w_stable = 1'b1;
      end
      w_pat[j] = pwm_out;
      if (j < 15 && int'(level_o) != w_lvl) w_stable = 1'b0;
      if (j == 15 && q_per.size() > 0) begin
        pp = q_per.pop_front();
        if (pp.chk) begin
          check("period_level", w_lvl, pp.lvl);
          check("level_stable", int'(w_stable), 1);
`ifdef AUDIO_SDM_EN
          check("sdm_ones", $countones(w_pat), pp.lvl);
          if (edge_n == 16 && pp.lvl == 8)
            check("sdm_alternate", int'(w_pat), 'hAAAA);
`else
          mask = (1 << pp.lvl) - 1;
          check("pwm_pattern", int'(w_pat), mask);
`endif
        end
      end
    end
  end

  task automatic run_to(input int n);
    for (int i = 0; i < 3000; i++) begin
      if (edge_n >= n) break;
      @(negedge clock);
    end
    check("reached_edge", int'(edge_n >= n), 1);
  endtask

  task automatic drain();
    check("tick_q_left", q_tick.size(), 0);
    check("gain_q_left", q_gain.size(), 0);
    check("period_q_left", q_per.size(), 0);
    q_tick.delete();
    q_gain.delete();
    q_per.delete();
  endtask

  task automatic do_reset(input logic [3:0] s);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("rst_sample_ena", int'(sample_ena), 0);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_level", int'(level_o), 8);
    check("rst_gain", int'(gain_o), 0);
    mute = 1'b1;
    #1;
    check("rst_muted_hi", int'(muted), 1);
    mute = 1'b0;
    #1;
    check("rst_muted_lo", int'(muted), 0);
    sample = s;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  int ticks_a[16] = '{13, 25, 38, 50, 63, 75, 88, 100,
                      113, 125, 138, 150, 163, 175, 188, 200};
  int per_ab[30]  = '{8, 8, 8, 9, 9, 10, 11, 11, 12, 12,
                      13, 13, 14, 15, 0, 1, 2, 2, 3, 4,
                      4, 5, 5, 6, 7, 7, 8, 8, 8, 8};

  initial begin
    // Ramp up on sample 15, then mute with sample 0
    do_reset(4'd15);
    foreach (ticks_a[i]) q_tick.push_back(ticks_a[i]);
    for (int g = 1; g <= 16; g++) q_gain.push_back('{g, 0});
    for (int g = 15; g >= 0; g--) q_gain.push_back('{g, (g == 0) ? 1 : 0});
    q_gain.push_back('{0, 1});
    q_gain.push_back('{0, 1});
    foreach (per_ab[i]) q_per.push_back('{1'b1, per_ab[i]});
    run_to(205);
    mute = 1'b1;
    sample = 4'd0;
    run_to(420);
    sample = 4'd15;
    run_to(490);
    drain();

    // Unity gain, sample steps 3 -> 12 between ticks
    do_reset(4'd3);
    for (int g = 1; g <= 16; g++) q_gain.push_back('{g, 0});
    q_gain.push_back('{16, 0});
    for (int i = 0; i < 13; i++) q_per.push_back('{1'b0, 0});
    q_per.push_back('{1'b1, 3});
    q_per.push_back('{1'b1, 12});
    q_per.push_back('{1'b1, 12});
    run_to(205);
    sample = 4'd12;
    run_to(260);
    drain();

    // Reset pulsed mid-ramp at gain 7
    do_reset(4'd15);
    for (int g = 1; g <= 7; g++) q_gain.push_back('{g, 0});
    run_to(95);
    drain();
    do_reset(4'd15);
    q_tick.push_back(13);
    q_tick.push_back(25);
    q_gain.push_back('{1, 0});
    run_to(30);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/audio_out.md
Name: audio_out

Overview:
Output stage of the audio path; the tone generator sits directly upstream of it.
- Generates the `sample_ena` tick at SAMPLE_RATE from the system clock using a fractional accumulator.
- Captures the generator's 4-bit offset-binary sample and applies a click-free mute/unmute gain ramp.
- Drives a 1-bit audio pin with PWM, or with first-order sigma-delta when the optional feature is compiled in.

Parameters:
- CLK_HZ, 25000000, system clock frequency in Hz; must satisfy CLK_HZ >= 2*SAMPLE_RATE.
- SAMPLE_RATE, 16384, sample tick rate in Hz; must match the generator's SAMPLE_RATE.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- sample  in  4  offset-binary sample from the generator (8 = midscale).
- mute  in  1  1 = ramp gain to 0; 0 = ramp gain to unity.
- sample_ena  out  1  registered one-clock tick at SAMPLE_RATE, feeds the generator.
- pwm_out  out  1  registered 1-bit audio output.
- level_o  out  4  currently applied output level.
- gain_o  out  5  current gain, 0..16 (16 = unity).
- muted  out  1  high when mute=1 and gain==0.

Behaviour:
- Reset: clock, reset decided as above.
  - acc=0, sample_ena=0, ena_d=0, smp=8, gain=0, level=8, level_reg=8, pwm_cnt=0, pwm_out=0.
  - Reset mid-operation aborts everything immediately; the next sample_ena comes a full ceil(CLK_HZ/SAMPLE_RATE) clocks after release.
- Tick generator, every clock:
  - nxt = acc + SAMPLE_RATE.
  - If nxt >= CLK_HZ: acc <= nxt - CLK_HZ, sample_ena <= 1. Otherwise acc <= nxt, sample_ena <= 0.
  - acc width is clog2(CLK_HZ)+1 bits, no overflow.
  - Exactly SAMPLE_RATE ticks per CLK_HZ clocks; the tick is never high on two consecutive clocks.
- Capture:
  - ena_d <= sample_ena, so the upstream register update settles first.
  - On a clock with ena_d=1: smp <= sample.
  - In the same clock, gain moves one step toward the target (0 if mute, else 16), saturating at the target.
  - A mute change takes effect at the next capture; a full ramp takes 16 captures.
- Scaling, combinational from smp and gain:
  - s = smp - 8, signed -8..7.
  - scaled = (s*gain) >>> 4, arithmetic (floor); level = scaled + 8.
  - Result is always 0..15. gain=16 gives level=smp; gain=0 gives level=8 for any sample.
  - level_o = level_reg.
- PWM (default build):
  - pwm_cnt is a 4-bit free-running counter, +1 every clock, wrapping 15->0.
  - When pwm_cnt==15: level_reg <= level, so updates land only on period boundaries and no mid-period glitch occurs.
  - pwm_out <= (pwm_cnt < level_reg): high for level_reg clocks of each 16. level 0 stays low; level 15 gives 15/16 duty.
- muted = mute & (gain==0), combinational.

Optional Feature:
AUDIO_SDM_EN
- Defined: the PWM comparator is replaced by a first-order sigma-delta modulator.
  - Adds a 4-bit sdm_acc, reset 0. Every clock: {carry, sdm_acc} <= sdm_acc + level_reg, and pwm_out <= carry.
  - pwm_cnt and the period-boundary update remain, so level_reg timing is unchanged.
  - Ones density over any 16 clocks equals level_reg/16 exactly; level 8 yields alternating 1,0.
- Undefined: PWM as above; sdm_acc is not instantiated.

Test Plan:
1. CLK_HZ=100, SAMPLE_RATE=8, reset released -> sample_ena first high after clock edge 13, then edges 25, 38, 50; periods alternate 13/12; 8 ticks per 100 clocks.
2. Default params, sample held 15, mute=0 from reset -> gain_o 0,1,..,16 over 16 captures; level_o settles to 15; pwm_out duty 15/16.
3. gain=16, mute asserted with sample=0 -> gain steps down 1 per capture; level rises 0->8 monotonically; muted=1 after 16 captures; level_o=8 regardless of sample.
4. gain=16, sample changes 3->12 between two ticks -> level_o changes only on the clock after a pwm_cnt==15 edge; no pwm_out period shows an intermediate duty.
5. Reset pulsed mid-ramp (gain=7) -> all outputs return to reset values at once; sample_ena stays 0 for 12 clocks after release (CLK_HZ=100 case).
6. AUDIO_SDM_EN defined, level_reg=8 -> pwm_out 0,1,0,1...; level_reg=3 -> exactly 3 ones per 16 clocks; level_reg=0 -> constant 0.
